// File: rtl/port1_arbiter.sv
// port1_arbiter: two-master arbiter for the downstream port1 bus.
//   master 0 = CPU data, master 1 = debug master.
// Arbitration policy in FREE is selected at build time:
//   PORT1_ARB_ROUND_ROBIN_EN defined   -> round-robin on the last-granted master
//   PORT1_ARB_ROUND_ROBIN_EN undefined -> fixed priority, debug master wins
// A master holding its lock input keeps the grant for up to MAX_LOCK
// consecutive granted transfers. Read data from port1 returns one cycle
// after the accepted read and is steered back to the master that issued it.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FREE  | no lock held, winner chosen by the arbitration policy
// ST_LOCK0 | master 0 holds the grant; master 1 is blocked
// ST_LOCK1 | master 1 holds the grant; master 0 is blocked

module port1_arbiter #(
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic        m0_resp,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic        m1_resp,
    output logic [31:0] m1_rdata,

    output logic        port1_req,
    output logic        port1_we,
    output logic [31:0] port1_addr,
    output logic [31:0] port1_wdata,
    output logic [3:0]  port1_be,
    input  logic [31:0] port1_rdata
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  lock_cnt, lock_cnt_nxt;
    logic        last_gnt, last_gnt_nxt;
    logic        pend_rd;
    logic        pend_owner;

    logic        gnt_sel;
    logic        gnt_vld;
    logic        sel_lock;
    logic        sel_we;
    logic [7:0]  lock_cnt_inc;

    // Pick the master that owns the port this cycle.
    always_comb begin
        gnt_sel = 1'b0;
        gnt_vld = 1'b0;
        case (state)
            ST_FREE: begin
                gnt_vld = m0_req | m1_req;
`ifdef PORT1_ARB_ROUND_ROBIN_EN
                if (m0_req && m1_req) begin
                    gnt_sel = ~last_gnt;
                end else begin
                    gnt_sel = m1_req;
                end
`else
                gnt_sel = m1_req;
`endif
            end
            ST_LOCK0: begin
                gnt_sel = 1'b0;
                gnt_vld = m0_req;
            end
            ST_LOCK1: begin
                gnt_sel = 1'b1;
                gnt_vld = m1_req;
            end
            default: begin
                gnt_sel = 1'b0;
                gnt_vld = 1'b0;
            end
        endcase
    end

    assign sel_lock     = gnt_sel ? m1_lock : m0_lock;
    assign sel_we       = gnt_sel ? m1_we   : m0_we;
    assign lock_cnt_inc = lock_cnt + 8'd1;

    assign m0_ack = gnt_vld & ~gnt_sel;
    assign m1_ack = gnt_vld &  gnt_sel;

    assign port1_req   = gnt_vld;
    assign port1_we    = sel_we;
    assign port1_addr  = gnt_sel ? m1_addr  : m0_addr;
    assign port1_wdata = gnt_sel ? m1_wdata : m0_wdata;
    assign port1_be    = gnt_sel ? m1_be    : m0_be;

    // Lock state machine: enter on a locked grant, leave on unlock or budget exhausted.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        last_gnt_nxt = last_gnt;
        case (state)
            ST_FREE: begin
                if (gnt_vld) begin
                    last_gnt_nxt = gnt_sel;
                    // With a budget of one, the first transfer already spends it.
                    if (sel_lock && (MAX_LOCK_C > 8'd1)) begin
                        state_nxt    = gnt_sel ? ST_LOCK1 : ST_LOCK0;
                        lock_cnt_nxt = 8'd1;
                    end
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (gnt_vld) begin
                    last_gnt_nxt = gnt_sel;
                    if (!sel_lock || (lock_cnt_inc >= MAX_LOCK_C)) begin
                        state_nxt    = ST_FREE;
                        lock_cnt_nxt = 8'd0;
                    end else begin
                        lock_cnt_nxt = lock_cnt_inc;
                    end
                end else if (!sel_lock) begin
                    // Owner idle and no longer asking to hold the port.
                    state_nxt    = ST_FREE;
                    lock_cnt_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt    = ST_FREE;
                lock_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_FREE;
            lock_cnt <= 8'd0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Remember who issued an accepted read so the returning data finds its owner.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_rd    <= 1'b0;
            pend_owner <= 1'b0;
        end else begin
            pend_rd    <= gnt_vld & ~sel_we;
            pend_owner <= gnt_sel;
        end
    end

    assign m0_resp  = pend_rd & ~pend_owner;
    assign m1_resp  = pend_rd &  pend_owner;
    assign m0_rdata = m0_resp ? port1_rdata : 32'd0;
    assign m1_rdata = m1_resp ? port1_rdata : 32'd0;

endmodule

// File: tb/tb_port1_arbiter.sv
// Directed bench for port1_arbiter with a read-response scoreboard.
// Expected arbitration outcomes depend on PORT1_ARB_ROUND_ROBIN_EN where the
// policies differ; the same macro selects the matching expectations here.

module tb_port1_arbiter;

    localparam int          MAX_LOCK = 4;
    localparam logic [31:0] RD_KEY   = 32'h5A5A_0000;

    logic        clk_i;
    logic        rst_i;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_be;
    logic        m0_ack, m0_resp;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_be;
    logic        m1_ack, m1_resp;
    logic [31:0] m1_rdata;
    logic        port1_req, port1_we;
    logic [31:0] port1_addr, port1_wdata;
    logic [3:0]  port1_be;
    logic [31:0] port1_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        int          due;
    } sb_t;
    sb_t sb_q[$];

    port1_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_be       (m0_be),
        .m0_lock     (m0_lock),
        .m0_ack      (m0_ack),
        .m0_resp     (m0_resp),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_be       (m1_be),
        .m1_lock     (m1_lock),
        .m1_ack      (m1_ack),
        .m1_resp     (m1_resp),
        .m1_rdata    (m1_rdata),
        .port1_req   (port1_req),
        .port1_we    (port1_we),
        .port1_addr  (port1_addr),
        .port1_wdata (port1_wdata),
        .port1_be    (port1_be),
        .port1_rdata (port1_rdata)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Downstream memory: read data is a fixed function of the address, one cycle later.
    always @(posedge clk_i) port1_rdata <= port1_addr ^ RD_KEY;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response checker: every cycle, resp/rdata must match the scoreboard head.
    always @(negedge clk_i) begin
        bit          e0, e1;
        logic [31:0] d0, d1;
        e0 = 1'b0; e1 = 1'b0; d0 = 32'd0; d1 = 32'd0;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            if (sb_q[0].owner) begin
                e1 = 1'b1; d1 = sb_q[0].data;
            end else begin
                e0 = 1'b1; d0 = sb_q[0].data;
            end
            void'(sb_q.pop_front());
        end
        chk("m0_resp",  32'(m0_resp), 32'(e0));
        chk("m1_resp",  32'(m1_resp), 32'(e1));
        chk("m0_rdata", m0_rdata, d0);
        chk("m1_rdata", m1_rdata, d1);
    end

    task automatic m_set(input bit n, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit lock);
        if (n) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = 4'hF; m1_lock = lock;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = 4'hF; m0_lock = lock;
        end
    endtask

    task automatic idle_all();
        m_set(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        m_set(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Sample mid-cycle: grants and bus, and queue the read that should come back.
    task automatic sample(input string tag, input bit e0, input bit e1, input logic [31:0] eaddr);
        @(negedge clk_i);
        chk({tag, "_ack0"}, 32'(m0_ack), 32'(e0));
        chk({tag, "_ack1"}, 32'(m1_ack), 32'(e1));
        chk({tag, "_preq"}, 32'(port1_req), 32'(e0 | e1));
        if (e0 | e1) chk({tag, "_paddr"}, port1_addr, eaddr);
        if (e0 && !m0_we) sb_q.push_back('{1'b0, m0_addr ^ RD_KEY, cyc + 1});
        if (e1 && !m1_we) sb_q.push_back('{1'b1, m1_addr ^ RD_KEY, cyc + 1});
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input string tag, input bit e0, input bit e1, input logic [31:0] eaddr);
        sample(tag, e0, e1, eaddr);
        adv();
    endtask

    initial begin
        rst_i = 1'b0;
        idle_all();
        m1_req = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        // Combinational grant follows inputs while held in reset.
        chk("rst_ack0", 32'(m0_ack), 32'd0);
        chk("rst_ack1", 32'(m1_ack), 32'd1);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        m1_req = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        adv();

        // Both masters read simultaneously.
        m_set(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
        m_set(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
`ifdef PORT1_ARB_ROUND_ROBIN_EN
        step("rr_a", 1'b1, 1'b0, 32'h10);
        step("rr_b", 1'b0, 1'b1, 32'h20);
`else
        step("fp_a", 1'b0, 1'b1, 32'h20);
        step("fp_b", 1'b0, 1'b1, 32'h20);
`endif
        idle_all();
        step("idle1", 1'b0, 1'b0, 32'd0);

        // Back-to-back alternating single-master reads.
        m_set(1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 1'b0);
        step("alt_a", 1'b1, 1'b0, 32'h30);
        idle_all();
        m_set(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0);
        step("alt_b", 1'b0, 1'b1, 32'h40);
        idle_all();
        m_set(1'b0, 1'b1, 1'b0, 32'h50, 32'd0, 1'b0);
        step("alt_c", 1'b1, 1'b0, 32'h50);
        idle_all();
        step("idle2", 1'b0, 1'b0, 32'd0);

        // Debug write: bus carries it for one cycle, no response follows.
        m_set(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
        sample("wr", 1'b0, 1'b1, 32'h8000_0000);
        chk("wr_we",    32'(port1_we), 32'd1);
        chk("wr_wdata", port1_wdata, 32'hDEAD_BEEF);
        chk("wr_be",    32'(port1_be), 32'hF);
        adv();
        idle_all();
        step("wr_idle", 1'b0, 1'b0, 32'd0);

        // Lock budget: m0 gets exactly MAX_LOCK acks, then m1.
        m_set(1'b0, 1'b1, 1'b0, 32'h70, 32'd0, 1'b1);
        step("lk1", 1'b1, 1'b0, 32'h70);
        m_set(1'b1, 1'b1, 1'b0, 32'h60, 32'd0, 1'b0);
        step("lk2", 1'b1, 1'b0, 32'h70);
        step("lk3", 1'b1, 1'b0, 32'h70);
        step("lk4", 1'b1, 1'b0, 32'h70);
        step("lk5", 1'b0, 1'b1, 32'h60);
        idle_all();
        step("idle3", 1'b0, 1'b0, 32'd0);

        // Idle owner keeps the lock while lock stays high.
        m_set(1'b0, 1'b1, 1'b0, 32'hA0, 32'd0, 1'b1);
        step("lh1", 1'b1, 1'b0, 32'hA0);
        m_set(1'b0, 1'b0, 1'b0, 32'hA0, 32'd0, 1'b1);
        m_set(1'b1, 1'b1, 1'b0, 32'hB0, 32'd0, 1'b0);
        step("lh2", 1'b0, 1'b0, 32'd0);
        m_set(1'b0, 1'b0, 1'b0, 32'hA0, 32'd0, 1'b0);
        step("lh3", 1'b0, 1'b0, 32'd0);
        step("lh4", 1'b0, 1'b1, 32'hB0);
        idle_all();
        step("idle4", 1'b0, 1'b0, 32'd0);

        // Lock dropped on a granted transfer releases the port.
        m_set(1'b0, 1'b1, 1'b0, 32'hC0, 32'd0, 1'b1);
        step("lr1", 1'b1, 1'b0, 32'hC0);
        m_set(1'b0, 1'b1, 1'b0, 32'hC4, 32'd0, 1'b0);
        m_set(1'b1, 1'b1, 1'b0, 32'hD0, 32'd0, 1'b0);
        step("lr2", 1'b1, 1'b0, 32'hC4);
        step("lr3", 1'b0, 1'b1, 32'hD0);
        idle_all();
        step("idle5", 1'b0, 1'b0, 32'd0);

        // Locked read, then reset: no response, lock cleared.
        m_set(1'b0, 1'b1, 1'b0, 32'hE0, 32'd0, 1'b1);
        @(negedge clk_i);
        chk("rs_ack0", 32'(m0_ack), 32'd1);
        adv();
        idle_all();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rs_m0_resp",  32'(m0_resp), 32'd0);
        chk("rs_m0_rdata", m0_rdata, 32'd0);
        adv();
        rst_i = 1'b1;
        m_set(1'b1, 1'b1, 1'b0, 32'hF0, 32'd0, 1'b0);
        step("post_rst", 1'b0, 1'b1, 32'hF0);
        idle_all();
        step("idle6", 1'b0, 1'b0, 32'd0);
        step("idle7", 1'b0, 1'b0, 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
